// File: rtl/ntt_job_seq.sv
// ntt_job_seq: sequences one NTT/INTT job. It loads coefficient pairs into the
// core, captures the core's result pairs into a skid FIFO, and streams them out
// with out_last marking the final delivered pair of the job.
module ntt_job_seq #(
    parameter int FIFO_DEPTH = 8,
    parameter int NPAIRS     = 128
) (
    input  logic        clk,
    input  logic        rst,
    // job request
    input  logic        job_valid,
    input  logic        job_mode,
    output logic        job_ready,
    // coefficient pair input
    input  logic        in_valid,
    input  logic [15:0] in_data_a,
    input  logic [15:0] in_data_b,
    output logic        in_ready,
    // core drive
    output logic        core_start,
    output logic        core_mode,
    output logic        core_we,
    output logic [7:0]  core_addr_a,
    output logic [7:0]  core_addr_b,
    output logic [15:0] core_data_a,
    output logic [15:0] core_data_b,
    // core status / results
    input  logic        core_done,
    input  logic        core_wr_req,
    input  logic [15:0] core_out_a,
    input  logic [15:0] core_out_b,
    // result stream
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data_a,
    output logic [15:0] out_data_b,
    output logic        out_last,
    // status
    output logic        busy,
    output logic        err_overflow
);

    localparam int CW  = $clog2(NPAIRS + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  NP     = CW'(NPAIRS);
    localparam logic [CW-1:0]  NP_M1  = CW'(NPAIRS - 1);
    localparam logic [FCW-1:0] F_FULL = FCW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]  beat_cnt;     // beats accepted in LOAD, saturates at NPAIRS
    logic [CW-1:0]  cap_cnt;      // result pairs seen in RUN (stored or dropped)
    logic           done_seen;    // core_done observed earlier in this RUN
    logic           last_popped;  // out_last pair already left the FIFO

    logic [15:0]           mem_a [FIFO_DEPTH];
    logic [15:0]           mem_b [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [PW-1:0]         wr_ptr, rd_ptr, tail_ptr;
    logic [FCW-1:0]        fcnt;

    logic accept_job, accept_beat;
    logic fifo_empty, fifo_full;
    logic pop, capture, cap_final, push, drop;

    // Handshakes, FIFO status and the push/pop/drop decisions.
    always_comb begin
        job_ready   = (state == IDLE);
        busy        = (state != IDLE);
        core_start  = (state == LOAD);
        in_ready    = (state == LOAD) && (beat_cnt != NP);
        accept_job  = job_valid && job_ready;
        accept_beat = in_valid && in_ready;
        fifo_empty  = (fcnt == '0);
        fifo_full   = (fcnt == F_FULL);
        out_valid   = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
        pop         = out_valid && out_ready;
        capture     = (state == RUN) && core_wr_req && (cap_cnt != NP);
        cap_final   = capture && (cap_cnt == NP_M1);
        // a simultaneous pop frees the slot, so a full FIFO still accepts
        push        = capture && (!fifo_full || pop);
        drop        = capture && fifo_full && !pop;
        tail_ptr    = wr_ptr - PW'(1);
        out_data_a  = mem_a[rd_ptr];
        out_data_b  = mem_b[rd_ptr];
        out_last    = out_valid && mem_last[rd_ptr];
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept_job) state_nxt = LOAD;
            // beat_cnt hits NPAIRS the cycle the final write is on the core bus
            LOAD:  if (beat_cnt == NP) state_nxt = RUN;
            // an early core_done is remembered; leave only once all pairs arrived
            RUN:   if ((core_done || done_seen) && (cap_cnt == NP)) state_nxt = DRAIN;
            DRAIN: if (last_popped || (pop && out_last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, status flags and the registered core write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            cap_cnt      <= '0;
            done_seen    <= 1'b0;
            last_popped  <= 1'b0;
            err_overflow <= 1'b0;
            core_mode    <= 1'b0;
            core_we      <= 1'b0;
            core_addr_a  <= '0;
            core_addr_b  <= '0;
            core_data_a  <= '0;
            core_data_b  <= '0;
        end else begin
            state   <= state_nxt;
            core_we <= accept_beat;
            if (accept_job) begin
                core_mode    <= job_mode;
                beat_cnt     <= '0;
                cap_cnt      <= '0;
                done_seen    <= 1'b0;
                last_popped  <= 1'b0;
                err_overflow <= 1'b0;
            end
            // addresses hold across input gaps; only an accepted beat moves them
            if (accept_beat) begin
                core_addr_a <= 8'({beat_cnt, 1'b0});
                core_addr_b <= 8'({beat_cnt, 1'b1});
                core_data_a <= in_data_a;
                core_data_b <= in_data_b;
                beat_cnt    <= beat_cnt + CW'(1);
            end
            if (capture)                  cap_cnt      <= cap_cnt + CW'(1);
            if (drop)                     err_overflow <= 1'b1;
            if ((state == RUN) && core_done) done_seen <= 1'b1;
            if (pop && out_last)          last_popped  <= 1'b1;
        end
    end

    // FIFO pointers, occupancy and per-entry last tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcnt     <= '0;
            mem_last <= '0;
        end else if (accept_job) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) begin
                mem_last[wr_ptr] <= cap_final;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            // final pair dropped: the newest stored pair becomes the job's last
            if (drop && cap_final) mem_last[tail_ptr] <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fcnt <= fcnt + FCW'(1);
                2'b01:   fcnt <= fcnt - FCW'(1);
                default: fcnt <= fcnt;
            endcase
        end
    end

    // FIFO data storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= core_out_a;
            mem_b[wr_ptr] <= core_out_b;
        end
    end

endmodule

// File: tb/tb_ntt_job_seq.sv
// Directed bench for ntt_job_seq: load, stalls, output path, backpressure,
// reset mid-job and early core_done.
module tb_ntt_job_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_valid = 1'b0, job_mode = 1'b0, job_ready;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_data_a = '0, in_data_b = '0;
    logic        core_start, core_mode, core_we;
    logic [7:0]  core_addr_a, core_addr_b;
    logic [15:0] core_data_a, core_data_b;
    logic        core_done = 1'b0, core_wr_req = 1'b0;
    logic [15:0] core_out_a = '0, core_out_b = '0;
    logic        out_valid, out_ready = 1'b0, out_last;
    logic [15:0] out_data_a, out_data_b;
    logic        busy, err_overflow;

    int n_pass = 0;
    int n_total = 0;

    ntt_job_seq #(.FIFO_DEPTH(8), .NPAIRS(128)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_mode(job_mode), .job_ready(job_ready),
        .in_valid(in_valid), .in_data_a(in_data_a), .in_data_b(in_data_b), .in_ready(in_ready),
        .core_start(core_start), .core_mode(core_mode), .core_we(core_we),
        .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
        .core_data_a(core_data_a), .core_data_b(core_data_b),
        .core_done(core_done), .core_wr_req(core_wr_req),
        .core_out_a(core_out_a), .core_out_b(core_out_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_a(out_data_a), .out_data_b(out_data_b), .out_last(out_last),
        .busy(busy), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Observation of the core write port and the result stream (stats only).
    int          we_cnt, we_run, we_max, hold_err, addr_err;
    int          out_n, last_cnt, last_idx;
    logic [7:0]  last_a;
    logic [15:0] we_a [256];
    logic [15:0] we_b [256];
    logic [15:0] oa [256];
    logic [15:0] ob [256];

    always @(negedge clk) begin
        if (!rst) begin
            we_cnt = 0; we_run = 0; we_max = 0; hold_err = 0; addr_err = 0;
            out_n = 0; last_cnt = 0; last_idx = -1; last_a = '0;
        end else begin
            if (core_we) begin
                if (core_addr_a !== 8'(2 * we_cnt) || core_addr_b !== 8'(2 * we_cnt + 1)) addr_err++;
                if (we_cnt < 256) begin
                    we_a[we_cnt] = core_data_a;
                    we_b[we_cnt] = core_data_b;
                end
                we_cnt++;
                we_run++;
                if (we_run > we_max) we_max = we_run;
                last_a = core_addr_a;
            end else begin
                we_run = 0;
                if (we_cnt > 0 && core_addr_a !== last_a) hold_err++;
            end
            if (out_valid && out_ready) begin
                if (out_n < 256) begin
                    oa[out_n] = out_data_a;
                    ob[out_n] = out_data_b;
                end
                if (out_last) begin
                    last_cnt++;
                    last_idx = out_n;
                end
                out_n++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        job_valid = 0; in_valid = 0; core_done = 0; core_wr_req = 0; out_ready = 0;
        rst = 0;
        repeat (3) tick();
        rst = 1;
        tick();
    endtask

    task automatic start_job(input logic m);
        job_mode  = m;
        job_valid = 1;
        tick();
        job_valid = 0;
    endtask

    // Feeds n beats: data_a = ba + step*k, data_b = bb + step*k; gap=1 toggles in_valid.
    task automatic load_beats(input int n, input int ba, input int bb, input int step, input bit gap);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 2000) begin
            in_valid  = !gap || (cyc % 2 == 0);
            in_data_a = 16'(ba + step * k);
            in_data_b = 16'(bb + step * k);
            if (in_valid && in_ready) k++;
            tick();
            cyc++;
        end
        in_valid = 0;
    endtask

    // Core model: n result pairs A000+i / 5000+i, optional idle done pulse at done_at,
    // then a trailing done pulse.
    task automatic run_core(input int n, input int done_at);
        for (int i = 0; i < n; i++) begin
            if (i == done_at) begin
                core_wr_req = 0;
                core_done = 1;
                tick();
                core_done = 0;
            end
            core_wr_req = 1;
            core_out_a  = 16'(16'hA000 + i);
            core_out_b  = 16'(16'h5000 + i);
            tick();
        end
        core_wr_req = 0;
        core_done = 1;
        tick();
        core_done = 0;
    endtask

    task automatic wait_idle(output bit ok);
        int c = 0;
        while (!job_ready && c < 400) begin
            tick();
            c++;
        end
        ok = job_ready;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (job_ready !== 1'b1) $display("FAIL reset_job_ready: got %b want 1", job_ready); else n_pass++;
        n_total++;
        if ({busy, in_ready, core_start, core_we, core_mode, out_valid, out_last, err_overflow} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000",
                     {busy, in_ready, core_start, core_we, core_mode, out_valid, out_last, err_overflow});
        else n_pass++;
        n_total++;
        if ({core_addr_a, core_addr_b, core_data_a, core_data_b} !== 48'h0)
            $display("FAIL reset_core_bus: got %h want 0", {core_addr_a, core_addr_b, core_data_a, core_data_b});
        else n_pass++;
    endtask

    task automatic test_basic_ntt();
        int bad = 0;
        do_reset();
        start_job(0);
        n_total++;
        if ({busy, job_ready, core_start, in_ready, core_mode} !== 5'b10110)
            $display("FAIL basic_load_state: got %b want 10110", {busy, job_ready, core_start, in_ready, core_mode});
        else n_pass++;
        load_beats(128, 0, 1, 2, 0);
        n_total++;
        if ({core_we, core_start, core_addr_a, core_addr_b} !== {2'b11, 8'd254, 8'd255})
            $display("FAIL basic_final_write: got we=%b start=%b a=%0d b=%0d want 1 1 254 255",
                     core_we, core_start, core_addr_a, core_addr_b);
        else n_pass++;
        tick();
        n_total++;
        if ({core_start, core_we, busy, in_ready, job_ready} !== 5'b00100)
            $display("FAIL basic_run_entry: got %b want 00100", {core_start, core_we, busy, in_ready, job_ready});
        else n_pass++;
        n_total++;
        if (we_cnt !== 128 || we_max !== 128 || addr_err !== 0)
            $display("FAIL basic_we_stream: got cnt=%0d run=%0d addr_err=%0d want 128 128 0", we_cnt, we_max, addr_err);
        else n_pass++;
        for (int k = 0; k < 128; k++)
            if (we_a[k] !== 16'(2 * k) || we_b[k] !== 16'(2 * k + 1)) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL basic_we_data: got %0d bad beats want 0", bad); else n_pass++;
    endtask

    task automatic test_stalls();
        int bad = 0;
        do_reset();
        start_job(1);
        n_total++;
        if (core_mode !== 1'b1) $display("FAIL stall_mode: got %b want 1", core_mode); else n_pass++;
        load_beats(128, 16'h3000, 16'h4000, 1, 1);
        tick();
        tick();
        n_total++;
        if (we_cnt !== 128 || we_max !== 1)
            $display("FAIL stall_we_pulses: got cnt=%0d maxrun=%0d want 128 1", we_cnt, we_max);
        else n_pass++;
        n_total++;
        if (addr_err !== 0 || hold_err !== 0)
            $display("FAIL stall_addr: got addr_err=%0d hold_err=%0d want 0 0", addr_err, hold_err);
        else n_pass++;
        for (int k = 0; k < 128; k++)
            if (we_a[k] !== 16'(16'h3000 + k) || we_b[k] !== 16'(16'h4000 + k)) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL stall_data: got %0d bad beats want 0", bad); else n_pass++;
    endtask

    task automatic test_output_path();
        bit ok;
        int bad = 0;
        do_reset();
        start_job(1);
        load_beats(128, 0, 1, 2, 0);
        tick();
        out_ready = 1;
        run_core(128, -1);
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL out_idle_timeout: got job_ready=%b want 1", job_ready); else n_pass++;
        n_total++;
        if (out_n !== 128 || last_cnt !== 1 || last_idx !== 127)
            $display("FAIL out_count_last: got n=%0d lasts=%0d idx=%0d want 128 1 127", out_n, last_cnt, last_idx);
        else n_pass++;
        for (int i = 0; i < 128; i++)
            if (oa[i] !== 16'(16'hA000 + i) || ob[i] !== 16'(16'h5000 + i)) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL out_order: got %0d bad pairs want 0", bad); else n_pass++;
        n_total++;
        if ({err_overflow, busy, core_mode} !== 3'b001)
            $display("FAIL out_status: got %b want 001", {err_overflow, busy, core_mode});
        else n_pass++;
        out_ready = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = 0;
        do_reset();
        start_job(0);
        load_beats(128, 0, 1, 2, 0);
        tick();
        out_ready = 0;
        run_core(128, -1);
        tick();
        n_total++;
        if ({err_overflow, out_valid, out_data_a, out_data_b} !== {2'b11, 16'hA000, 16'h5000})
            $display("FAIL bp_hold: got ovf=%b vld=%b a=%h b=%h want 1 1 a000 5000",
                     err_overflow, out_valid, out_data_a, out_data_b);
        else n_pass++;
        out_ready = 1;
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL bp_idle_timeout: got job_ready=%b want 1", job_ready); else n_pass++;
        n_total++;
        if (out_n !== 8 || last_cnt !== 1 || last_idx !== 7)
            $display("FAIL bp_count_last: got n=%0d lasts=%0d idx=%0d want 8 1 7", out_n, last_cnt, last_idx);
        else n_pass++;
        for (int i = 0; i < 8; i++)
            if (oa[i] !== 16'(16'hA000 + i) || ob[i] !== 16'(16'h5000 + i)) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL bp_data: got %0d bad pairs want 0", bad); else n_pass++;
        n_total++;
        if (err_overflow !== 1'b1) $display("FAIL bp_ovf_sticky: got %b want 1", err_overflow); else n_pass++;
        // back-to-back: a new job is accepted straight away and clears the flag
        start_job(1);
        n_total++;
        if ({err_overflow, busy, core_mode} !== 3'b011)
            $display("FAIL bp_next_job: got %b want 011", {err_overflow, busy, core_mode});
        else n_pass++;
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_job(1);
        load_beats(50, 16'h1000, 16'h2000, 1, 0);
        in_valid  = 1;
        in_data_a = 16'h1032;
        in_data_b = 16'h2032;
        #2;
        rst = 0;
        #1;
        n_total++;
        if ({busy, in_ready, core_we, core_start, core_mode, out_valid, err_overflow} !== 7'b0)
            $display("FAIL rstmid_flags: got %b want 0000000",
                     {busy, in_ready, core_we, core_start, core_mode, out_valid, err_overflow});
        else n_pass++;
        n_total++;
        if ({core_addr_a, core_addr_b, core_data_a, core_data_b} !== 48'h0)
            $display("FAIL rstmid_core_bus: got %h want 0", {core_addr_a, core_addr_b, core_data_a, core_data_b});
        else n_pass++;
        in_valid = 0;
        tick();
        rst = 1;
        tick();
        start_job(0);
        load_beats(1, 16'h7000, 16'h7100, 1, 0);
        n_total++;
        if ({core_we, core_addr_a, core_addr_b, core_data_a, core_data_b} !== {1'b1, 8'd0, 8'd1, 16'h7000, 16'h7100})
            $display("FAIL rstmid_restart: got we=%b a=%0d b=%0d da=%h db=%h want 1 0 1 7000 7100",
                     core_we, core_addr_a, core_addr_b, core_data_a, core_data_b);
        else n_pass++;
    endtask

    task automatic test_early_done();
        bit ok;
        int bad = 0;
        do_reset();
        start_job(0);
        load_beats(128, 0, 1, 2, 0);
        tick();
        out_ready = 1;
        run_core(128, 100);
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL early_idle_timeout: got job_ready=%b want 1", job_ready); else n_pass++;
        n_total++;
        if (out_n !== 128 || last_cnt !== 1 || last_idx !== 127)
            $display("FAIL early_count_last: got n=%0d lasts=%0d idx=%0d want 128 1 127", out_n, last_cnt, last_idx);
        else n_pass++;
        for (int i = 0; i < 128; i++)
            if (oa[i] !== 16'(16'hA000 + i)) bad++;
        n_total++;
        if (bad !== 0 || err_overflow !== 1'b0)
            $display("FAIL early_data: got bad=%0d ovf=%b want 0 0", bad, err_overflow);
        else n_pass++;
        out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic_ntt();
        test_stalls();
        test_output_path();
        test_backpressure();
        test_reset_mid();
        test_early_done();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
